// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor responder: FSM states,
// register map and the read-mux helper.
package i2c_pkg;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h4B;
    localparam logic [7:0] DEF_DEV_ID   = 8'hCB;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_CFG      = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_MACK
    } state_t;

    function automatic logic [7:0] reg_read(
        input logic [7:0]  ptr,
        input logic [15:0] shadow,
        input logic [7:0]  cfg,
        input logic [7:0]  dev_id
    );
        logic [7:0] val;
        val = 8'h00;
        case (ptr)
            REG_TEMP_MSB: val = shadow[15:8];
            REG_TEMP_LSB: val = shadow[7:0];
            REG_CFG:      val = cfg;
            REG_ID:       val = dev_id;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line;
// emits the accepted level and single-cycle rise/fall pulses.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;

    // Reset to the idle-bus level so leaving reset does not fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
            cnt_reg  <= '0;
            level    <= 1'b1;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], line};
            rise     <= 1'b0;
            fall     <= 1'b0;
            if (sync_reg[1] == level) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
                cnt_reg <= '0;
                level   <= sync_reg[1];
                rise    <= sync_reg[1];
                fall    <= ~sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the board temperature sensor: pointer/config writes,
// coherent two-byte temperature reads, open-drain SDA with delayed data changes.
module i2c_temp_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [7:0] DEV_ID    = DEF_DEV_ID,
    parameter int         FILT_LEN  = 3,
    parameter int         HOLD_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    input  logic [15:0] temp_data,
    output logic [7:0]  cfg_reg,
    output logic        busy,
    output logic        wr_strobe
);
    localparam int HW = $clog2(HOLD_CLKS + 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    state_t        state_reg;
    logic [2:0]    bit_cnt_reg;
    logic          byte_done_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    tx_reg;
    logic [7:0]    ptr_reg;
    logic [15:0]   shadow_reg;
    logic          rw_reg;
    logic          mack_reg;
    logic          pend_low_reg;
    logic          hold_armed_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic          sda_low_reg;
    logic [7:0]    rd_byte;
    logic [7:0]    next_ptr;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .line(I2C_SCL),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .line(I2C_SDA),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    // Reset gates the driver directly so SDA lets go in the reset cycle itself.
    assign I2C_SDA = (sda_low_reg && !rst) ? 1'b0 : 1'bz;

    // After a master ACK the next byte comes from the incremented pointer.
    assign next_ptr = ptr_reg + 8'd1;
    assign rd_byte  = reg_read((state_reg == ST_MACK) ? next_ptr : ptr_reg,
                               shadow_reg, cfg_reg, DEV_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            byte_done_reg  <= 1'b0;
            shift_reg      <= '0;
            tx_reg         <= '0;
            ptr_reg        <= REG_TEMP_MSB;
            shadow_reg     <= '0;
            rw_reg         <= 1'b0;
            mack_reg       <= 1'b0;
            pend_low_reg   <= 1'b0;
            hold_armed_reg <= 1'b0;
            hold_cnt_reg   <= '0;
            sda_low_reg    <= 1'b0;
            cfg_reg        <= 8'h00;
            busy           <= 1'b0;
            wr_strobe      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;

            if (hold_armed_reg) begin
                if (hold_cnt_reg == '0) begin
                    sda_low_reg    <= pend_low_reg;
                    hold_armed_reg <= 1'b0;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
                end
            end

            if (sda_rise && scl_level) begin
                state_reg      <= ST_IDLE;
                busy           <= 1'b0;
                sda_low_reg    <= 1'b0;
                hold_armed_reg <= 1'b0;
            end else if (sda_fall && scl_level) begin
                state_reg      <= ST_ADDR;
                bit_cnt_reg    <= '0;
                byte_done_reg  <= 1'b0;
                sda_low_reg    <= 1'b0;
                hold_armed_reg <= 1'b0;
            end else if (scl_rise) begin
                case (state_reg)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shift_reg   <= {shift_reg[6:0], sda_level};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
                    end
                    ST_RDATA: begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
                    end
                    // The data byte is committed only once its ACK bit is clocked.
                    ST_WDATA_ACK: begin
                        if (ptr_reg == REG_CFG) begin
                            cfg_reg   <= shift_reg;
                            wr_strobe <= 1'b1;
                        end
                        ptr_reg <= next_ptr;
                    end
                    ST_MACK: mack_reg <= ~sda_level;
                    default: ;
                endcase
            end else if (scl_fall) begin
                hold_armed_reg <= 1'b1;
                hold_cnt_reg   <= HW'(HOLD_CLKS - 1);
                pend_low_reg   <= 1'b0;
                case (state_reg)
                    ST_ADDR: begin
                        if (byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            if (shift_reg[7:1] == DEV_ADDR) begin
                                state_reg    <= ST_ADDR_ACK;
                                busy         <= 1'b1;
                                rw_reg       <= shift_reg[0];
                                pend_low_reg <= 1'b1;
                                if (shift_reg[0]) shadow_reg <= temp_data;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_MACK: begin
                        if (state_reg == ST_ADDR_ACK && !rw_reg) begin
                            state_reg <= ST_PTR;
                        end else if (state_reg == ST_MACK && !mack_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            if (state_reg == ST_MACK) ptr_reg <= next_ptr;
                            state_reg     <= ST_RDATA;
                            bit_cnt_reg   <= '0;
                            byte_done_reg <= 1'b0;
                            pend_low_reg  <= ~rd_byte[7];
                            tx_reg        <= {rd_byte[6:0], 1'b0};
                        end
                    end
                    ST_PTR: begin
                        if (byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            ptr_reg       <= shift_reg;
                            state_reg     <= ST_PTR_ACK;
                            pend_low_reg  <= 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        if (byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            state_reg     <= ST_WDATA_ACK;
                            pend_low_reg  <= 1'b1;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: state_reg <= ST_WDATA;
                    ST_RDATA: begin
                        if (byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            state_reg     <= ST_MACK;
                        end else begin
                            pend_low_reg <= ~tx_reg[7];
                            tx_reg       <= {tx_reg[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bit-banged I2C master driving the responder; expectations are queued when
// stimulus is issued and a separate monitor process compares observations.
module tb_i2c_temp_responder;
    localparam int HALF = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [15:0] temp_data = 16'h0000;
    wire         sda;
    logic [7:0]  cfg_reg;
    logic        busy;
    logic        wr_strobe;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #20 clk = ~clk;

    i2c_temp_responder dut (
        .clk(clk),
        .rst(rst),
        .I2C_SCL(scl),
        .I2C_SDA(sda),
        .temp_data(temp_data),
        .cfg_reg(cfg_reg),
        .busy(busy),
        .wr_strobe(wr_strobe)
    );

    string       exp_name_q[$];
    logic [15:0] exp_val_q[$];
    logic [15:0] obs_val_q[$];
    int          checks = 0;
    int          errors = 0;

    int strobe_cycles  = 0;
    int dut_low_cycles = 0;
    int busy_cycles    = 0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cycles++;
        if (sda === 1'b0 && !m_sda_low) dut_low_cycles++;
        if (busy === 1'b1) busy_cycles++;
    end

    // Scoreboard monitor
    initial begin
        logic [15:0] o;
        logic [15:0] e;
        string       n;
        forever begin
            @(negedge clk);
            while (obs_val_q.size() > 0) begin
                o = obs_val_q.pop_front();
                checks++;
                if (exp_val_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_observation: got %h, no expectation queued", o);
                end else begin
                    n = exp_name_q.pop_front();
                    e = exp_val_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL %s: got %h, expected %h", n, o, e);
                    end else begin
                        $display("ok   %s: %h", n, o);
                    end
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input string name, input logic [15:0] v);
        exp_name_q.push_back(name);
        exp_val_q.push_back(v);
    endtask

    task automatic observe(input logic [15:0] v);
        obs_val_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        expect_val(name, exp);
        observe(got);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        clks(HALF / 2);
        scl = 1'b1;
        clks(HALF);
        m_sda_low = 1'b1;
        clks(HALF);
        scl = 1'b0;
        clks(HALF / 2);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        clks(HALF / 2);
        scl = 1'b1;
        clks(HALF);
        m_sda_low = 1'b0;
        clks(HALF);
    endtask

    task automatic put_bit(input bit b, input bit glitch);
        m_sda_low = ~b;
        clks(HALF / 2);
        scl = 1'b1;
        if (glitch) begin
            clks(HALF / 2);
            m_sda_low = b;
            clks(1);
            m_sda_low = ~b;
            clks(HALF / 2 - 1);
        end else begin
            clks(HALF);
        end
        scl = 1'b0;
        clks(HALF / 2);
    endtask

    task automatic get_bit(output bit b);
        m_sda_low = 1'b0;
        clks(HALF / 2);
        scl = 1'b1;
        clks(HALF / 2);
        b = (sda !== 1'b0);
        clks(HALF / 2);
        scl = 1'b0;
        clks(HALF / 2);
    endtask

    task automatic write_byte(input logic [7:0] d, input string name, input bit exp_ack,
                              input int glitch_bit);
        bit a;
        expect_val(name, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
        get_bit(a);
        observe({15'd0, ~a});
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp, input bit ack);
        logic [7:0] d;
        bit b;
        expect_val(name, {8'd0, exp});
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        observe({8'd0, d});
        put_bit(~ack, 1'b0);
    endtask

    initial begin
        int s0;
        int left;
        bit b;

        clks(4);
        chk("rst_cfg_reg", 16'(cfg_reg), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_wr_strobe", 16'(wr_strobe), 16'h0000);
        chk("rst_sda_released", 16'(sda), 16'h0001);
        rst = 1'b0;
        clks(10);

        // Write 0xA5 to the config register
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h96, "t1_addr_ack", 1'b1, -1);
        write_byte(8'h03, "t1_ptr_ack", 1'b1, -1);
        write_byte(8'hA5, "t1_data_ack", 1'b1, -1);
        chk("t1_cfg_reg", 16'(cfg_reg), 16'h00A5);
        chk("t1_strobe_cycles", 16'(strobe_cycles - s0), 16'd1);
        chk("t1_busy_before_stop", 16'(busy), 16'h0001);
        i2c_stop();
        chk("t1_busy_after_stop", 16'(busy), 16'h0000);

        // Two-byte temperature read via repeated START
        temp_data = 16'h1A80;
        i2c_start();
        write_byte(8'h96, "t2_addr_w_ack", 1'b1, -1);
        write_byte(8'h00, "t2_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t2_addr_r_ack", 1'b1, -1);
        read_byte("t2_msb", 8'h1A, 1'b1);
        read_byte("t2_lsb", 8'h80, 1'b0);
        clks(8);
        chk("t2_sda_released_after_nack", 16'(sda), 16'h0001);
        chk("t2_busy_held_after_nack", 16'(busy), 16'h0001);
        i2c_stop();
        chk("t2_busy_after_stop", 16'(busy), 16'h0000);

        // Coherency: temp_data changes between the two bytes
        i2c_start();
        write_byte(8'h96, "t3_addr_w_ack", 1'b1, -1);
        write_byte(8'h00, "t3_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t3_addr_r_ack", 1'b1, -1);
        read_byte("t3_msb", 8'h1A, 1'b1);
        temp_data = 16'h0C00;
        read_byte("t3_lsb_from_snapshot", 8'h80, 1'b0);
        i2c_stop();

        // Foreign address: never ACKed, never busy
        s0 = dut_low_cycles;
        left = busy_cycles;
        i2c_start();
        write_byte(8'h90, "t4_addr_nack", 1'b0, -1);
        write_byte(8'h03, "t4_byte_nack", 1'b0, -1);
        i2c_stop();
        chk("t4_dut_low_cycles", 16'(dut_low_cycles - s0), 16'd0);
        chk("t4_busy_cycles", 16'(busy_cycles - left), 16'd0);

        // ID register, then pointer wrap from 0xFF
        i2c_start();
        write_byte(8'h96, "t5_addr_w_ack", 1'b1, -1);
        write_byte(8'h0B, "t5_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t5_addr_r_ack", 1'b1, -1);
        read_byte("t5_dev_id", 8'hCB, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte(8'h96, "t5_wrap_addr_w_ack", 1'b1, -1);
        write_byte(8'hFF, "t5_wrap_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t5_wrap_addr_r_ack", 1'b1, -1);
        read_byte("t5_reg_ff", 8'h00, 1'b1);
        read_byte("t5_wrapped_msb", 8'h0C, 1'b0);
        i2c_stop();

        // One-cycle SDA glitches while SCL is high must not abort the write
        i2c_start();
        write_byte(8'h96, "t6_addr_ack", 1'b1, -1);
        write_byte(8'h03, "t6_ptr_ack_fake_start", 1'b1, 0);
        write_byte(8'h5A, "t6_data_ack_fake_stop", 1'b1, 7);
        chk("t6_cfg_reg", 16'(cfg_reg), 16'h005A);
        i2c_stop();

        // Reset in the middle of a read, then a clean transaction
        i2c_start();
        write_byte(8'h96, "t7_addr_w_ack", 1'b1, -1);
        write_byte(8'h00, "t7_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t7_addr_r_ack", 1'b1, -1);
        get_bit(b);
        clks(6);
        chk("t7_sda_driven_low", 16'(sda), 16'h0000);
        rst = 1'b1;
        clks(1);
        chk("t7_sda_released_on_rst", 16'(sda), 16'h0001);
        chk("t7_cfg_reg_after_rst", 16'(cfg_reg), 16'h0000);
        rst = 1'b0;
        clks(12);
        i2c_stop();
        i2c_start();
        write_byte(8'h96, "t7_clean_addr_ack", 1'b1, -1);
        write_byte(8'h03, "t7_clean_ptr_ack", 1'b1, -1);
        write_byte(8'h3C, "t7_clean_data_ack", 1'b1, -1);
        i2c_stop();
        chk("t7_clean_cfg_reg", 16'(cfg_reg), 16'h003C);
        i2c_start();
        write_byte(8'h96, "t7_rb_addr_w_ack", 1'b1, -1);
        write_byte(8'h03, "t7_rb_ptr_ack", 1'b1, -1);
        i2c_start();
        write_byte(8'h97, "t7_rb_addr_r_ack", 1'b1, -1);
        read_byte("t7_rb_cfg", 8'h3C, 1'b0);
        i2c_stop();

        clks(10);
        left = exp_val_q.size() - obs_val_q.size();
        chk("scoreboard_leftover", 16'(left), 16'd0);
        clks(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_temp_responder.md
Name: i2c_temp_responder

Overview:
I2C target (responder) that emulates the board's temperature sensor, answering the existing I2C master's transactions from a parallel temperature word. Used in simulation and on boards without the sensor fitted, so the full read path to the LED matrix (I2C master → converter → display) can be exercised. Runs on the 25 MHz system clock and oversamples SCL/SDA; drives SDA open-drain only.

Parameters:
DEV_ADDR, 7'h4B, 7-bit target address matched after START
DEV_ID, 8'hCB, constant returned from register 0x0B
FILT_LEN, 3, consecutive equal samples required before a synchronized SCL/SDA level is accepted
HOLD_CLKS, 8, clk cycles after SCL falling edge before the driven SDA value changes

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  synchronous, active-high reset
I2C_SCL  input  1  bus clock from master
I2C_SDA  inout  1  bus data; driven 0 or 'z' only, never 1
temp_data  input  16  live temperature, 13-bit two's complement in [15:3], [2:0] = 0
cfg_reg  output  8  configuration register 0x03, writable by master
busy  output  1  high from an address-matched START until STOP or an address mismatch
wr_strobe  output  1  one-cycle pulse when a data byte is written to cfg_reg

Behaviour:
- Reset:
  - SDA released ('z'); cfg_reg = 8'h00; busy = 0; wr_strobe = 0.
  - Register pointer = 0x00; state = IDLE.
  - Reset mid-transaction releases SDA in the same cycle and ignores the bus until the next START.
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA, then a FILT_LEN glitch filter.
  - Edges and conditions are detected on the filtered signals.
- Bus conditions:
  - START = SDA falling while SCL high; STOP = SDA rising while SCL high.
  - START in any state, including a repeated START, goes to ADDR.
  - STOP in any state goes to IDLE and releases SDA.
- Data sampling: SDA sampled on filtered SCL rising edge, MSB first.
- Data driving: driven SDA changes exactly HOLD_CLKS cycles after filtered SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If [7:1] == DEV_ADDR, go to ADDR_ACK and set busy. On mismatch, go to IDLE and never drive SDA.
  - ADDR_ACK: pull SDA low for the 9th clock.
    - R/W = 0 → PTR.
    - R/W = 1 → snapshot temp_data into a 16-bit shadow, then RDATA.
  - PTR: shift 8 bits into the pointer, then PTR_ACK (ACK) → WDATA.
  - WDATA: shift 8 bits. If pointer == 0x03, load cfg_reg and pulse wr_strobe. Other pointers discard the byte but are still ACKed. Then WDATA_ACK. Pointer increments after each data byte.
  - RDATA: drive the byte addressed by pointer:
    - 0x00 = shadow[15:8]
    - 0x01 = shadow[7:0]
    - 0x03 = cfg_reg
    - 0x0B = DEV_ID
    - others = 8'h00
    A 0 bit pulls SDA low; a 1 bit releases SDA. After 8 bits, release SDA → MACK.
  - MACK: sample master ACK on the 9th SCL rise. ACK (0) → increment pointer, RDATA. NACK (1) → IDLE (await STOP), busy held until STOP.
- Pointer arithmetic: 8-bit, wraps 0xFF → 0x00.
- Read coherency: the shadow is captured only at read-address ACK. A multi-byte read returns MSB and LSB from the same sample even if temp_data changes mid-read.
- Bit counter: 3-bit, reset on START and at each byte boundary.
- Edge cases:
  - A START arriving mid-byte aborts the byte; no register write occurs.
  - cfg_reg is only updated by a complete, ACKed byte.

Decomposition:
- Shared package (i2c_pkg):
  - State encoding localparams.
  - Register map constants: REG_TEMP_MSB = 0x00, REG_TEMP_LSB = 0x01, REG_CFG = 0x03, REG_ID = 0x0B.
  - Default DEV_ADDR.
- One sub-module, i2c_line_filter (instantiated twice): synchronizer plus glitch filter, outputs level, rise and fall pulses.

Test Plan:
- Address 0x4B write, ptr 0x03, data 0xA5 → three ACKs; cfg_reg = 8'hA5; wr_strobe high for exactly 1 cycle; busy falls on STOP.
- Write ptr 0x00, repeated START, read 2 bytes (master ACK then NACK) with temp_data = 16'h1A80 → bytes 0x1A, 0x80; SDA released after NACK.
- Same read with temp_data changed to 16'h0C00 between byte 1 and byte 2 → second byte still 0x80.
- Address 0x48 → no ACK on the 9th clock; SDA never driven low; busy stays 0.
- Ptr 0x0B read → 0xCB. Ptr 0xFF, read 2 bytes → 0x00, then shadow[15:8] (wrap to 0x00).
- 1-cycle SDA glitch while SCL high → no START/STOP detected. Assert rst mid-RDATA → SDA 'z' the next cycle; cfg_reg = 0x00; a subsequent clean transaction succeeds.
